// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Loads a processor instruction memory from a byte stream. After an accepted
// start, bytes are packed big-endian into 32-bit words and each word is
// written to consecutive word addresses from 0. The processor is held in
// reset (cpu_rst) from the accepted start until the load completes.
//
// Parameters
//   ADDR_W      instruction-memory word-address width, DEPTH = 2**ADDR_W
//
// Ports
//   clk         clock, rising edge active
//   rst_n       asynchronous active-low reset
//   start       one-cycle load request (ignored while busy)
//   num_words   words to load, sampled with an accepted start (0..DEPTH)
//   abort       cancel the load in progress (RECV/WRITE)
//   byte_valid  byte_data is valid
//   byte_data   incoming instruction byte
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction-memory write strobe
//   mem_addr    instruction-memory word address
//   mem_wdata   instruction word to write
//   cpu_rst     active-high processor reset
//   busy        load in progress
//   done        one-cycle pulse when a load completes
//   err         one-cycle pulse, the cycle after a start with num_words > DEPTH
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // DEPTH expressed in the (ADDR_W+1)-bit count domain.
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [31:0]       word_q;
  logic [1:0]        byte_cnt_q;
  // One bit wider than the address so that a DEPTH-word load can count to
  // DEPTH without the counter wrapping back onto address 0.
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   num_q;
  logic              cpu_rst_q;
  logic              err_q;

  logic              in_idle;
  logic              start_zero;
  logic              start_ok;
  logic              start_bad;
  logic              byte_take;
  logic              last_byte;
  logic              abort_load;
  logic [ADDR_W:0]   word_cnt_inc;

  // start is only looked at in IDLE, which is what makes it ignored while busy.
  assign in_idle      = (state_q == IDLE);
  assign start_zero   = in_idle && start && (num_words == '0);
  assign start_ok     = in_idle && start && (num_words != '0) && (num_words <= DEPTH_W);
  assign start_bad    = in_idle && start && (num_words > DEPTH_W);
  assign byte_take    = byte_ready && byte_valid;
  assign last_byte    = byte_take && (byte_cnt_q == 2'd3);
  assign abort_load   = abort && ((state_q == RECV) || (state_q == WRITE));
  assign word_cnt_inc = word_cnt_q + ONE_W;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start_zero) begin
          state_d = DONE;
        end else if (start_ok) begin
          state_d = RECV;
        end
      end

      RECV: begin
        byte_ready = 1'b1;
        // abort has priority over a coinciding 4th byte: no WRITE follows.
        if (abort) begin
          state_d = IDLE;
        end else if (last_byte) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        // An abort in this cycle cancels the write that is being presented.
        mem_we = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (word_cnt_inc == num_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: byte packing, counters, processor reset and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      num_q      <= '0;
      cpu_rst_q  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= start_bad;

      if (start_ok) begin
        num_q      <= num_words;
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
        cpu_rst_q  <= 1'b1;
      end else if (abort_load) begin
        // Partial bytes are dropped; cpu_rst stays asserted.
        byte_cnt_q <= '0;
      end else begin
        if (byte_take) begin
          // Shifting left lands the first byte of a word in [31:24].
          word_q     <= {word_q[23:0], byte_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        if (state_q == WRITE) begin
          word_cnt_q <= word_cnt_inc;
        end
      end

      if (state_q == DONE) begin
        cpu_rst_q <= 1'b0;
      end
    end
  end

  assign mem_addr  = word_cnt_q[ADDR_W-1:0];
  assign mem_wdata = word_q;
  assign cpu_rst   = cpu_rst_q;
  assign err       = err_q;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction-memory word-address width (DEPTH = 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a load.
REQ-005 num_words  input  ADDR_W+1  number of 32-bit words to load; sampled when start is accepted.
REQ-006 abort  input  1  cancel an in-progress load.
REQ-007 byte_valid  input  1  byte_data is valid.
REQ-008 byte_data  input  8  incoming instruction byte stream.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 cpu_rst  output  1  active-high reset to the processor.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  one-cycle pulse when a load completes.
REQ-016 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 The state machine SHALL have the states IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: when start=1 and 1<=num_words<=DEPTH, the block SHALL latch num_words, clear the word and byte counters, set cpu_rst=1, and go to RECV next cycle.
REQ-019 IDLE: when start=1 and num_words=0, the block SHALL go to DONE without any memory write.
REQ-020 IDLE: when start=1 and num_words>DEPTH, the block SHALL pulse err for one cycle, stay in IDLE, and leave cpu_rst unchanged.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted on a cycle where byte_valid && byte_ready.
REQ-022 Accepted bytes SHALL be packed big-endian: 1st into [31:24], 2nd [23:16], 3rd [15:8], 4th [7:0].
REQ-023 When the 4th byte is accepted in cycle N, the FSM SHALL enter WRITE so that in cycle N+1 mem_we=1, mem_wdata=packed word, and mem_addr=word counter (first word at address 0).
REQ-024 mem_we SHALL be high for exactly one cycle per word and SHALL be 0 in every other state.
REQ-025 After WRITE, the word counter SHALL increment; if it now equals the latched num_words the FSM SHALL go to DONE, otherwise back to RECV, with byte_ready=1 in cycle N+2.
REQ-026 The word counter SHALL be ADDR_W+1 bits wide; num_words=DEPTH SHALL write addresses 0..DEPTH-1 with no wrap to 0 within one load.
REQ-027 DONE SHALL last one cycle, in which done=1 and cpu_rst is cleared to 0 (cpu_rst low from the following edge); the next state is IDLE.
REQ-028 busy SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in RECV or WRITE SHALL return the FSM to IDLE on the next edge, suppress any pending write, discard partial bytes, and keep cpu_rst=1; done SHALL not pulse.
REQ-031 If abort and the 4th byte coincide, abort SHALL win, and no write SHALL occur.
REQ-032 A byte_valid gap mid-word SHALL stall the packing with no loss of the bytes already accepted.

Reset
REQ-033 While rst_n=0 the block SHALL immediately force: state IDLE, counters 0, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst=1.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further write after release; a new start is required.

Verification
REQ-035 start, num_words=2, bytes 8C,01,00,04,AC,02,00,08 back-to-back -> mem_we pulses with (addr 0, 8C010004) and (addr 1, AC020008); done one cycle after the second write; cpu_rst falls after done.
REQ-036 start, num_words=1, byte_valid deasserted for 3 cycles after the 2nd byte -> single write of the correctly packed word; byte_ready stays 1 during the gap.
REQ-037 start, num_words=0 -> done pulses with no mem_we; start, num_words=DEPTH+1 -> err pulse, busy stays 0.
REQ-038 num_words=3, abort asserted on the cycle the 2nd word's 4th byte is accepted -> only the address-0 write occurs; IDLE; cpu_rst=1; no done.
REQ-039 rst_n pulsed low asynchronously (between clock edges) mid-RECV -> outputs take reset values immediately; cpu_rst=1; no write after release.
REQ-040 start pulsed again while busy -> ignored; the load in progress completes unchanged.
